serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving operand and result width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request to add a and b, sampled on a clk edge.
REQ-005 The block SHALL have ports a and b, input, WIDTH bits each: operands, sampled only on the edge that accepts start.
REQ-006 The block SHALL have port busy, output, 1 bit: high while an addition is in progress (state SHIFT or DONE).
REQ-007 The block SHALL have port done, output, 1 bit: one-cycle pulse marking sum and cout valid.
REQ-008 The block SHALL have port sum, output, WIDTH bits: result, modulo 2^WIDTH.
REQ-009 The block SHALL have port cout, output, 1 bit: carry out of bit WIDTH-1.

Function
REQ-010 The block SHALL implement states IDLE, SHIFT and DONE.
REQ-011 In IDLE with start=1, the edge SHALL load a and b into shift registers, clear the carry flop and the bit counter, and go to SHIFT.
REQ-012 Each SHIFT edge SHALL add operand LSBs plus carry with a full adder, shift the sum bit into the sum register MSB-side (right shift), shift both operand registers right, update carry, and increment the counter.
REQ-013 After the WIDTH-th SHIFT edge, the block SHALL enter DONE; done SHALL be 1 for exactly that one cycle, and the next edge SHALL return the block to IDLE.
REQ-014 Latency SHALL be fixed: with start accepted on edge E0, done is high during the cycle after edge E(WIDTH), i.e. WIDTH+1 edges after acceptance.
REQ-015 sum and cout SHALL equal a+b (WIDTH+1-bit result) while done=1, and SHALL hold that value through IDLE until the next accepted start.
REQ-016 sum and cout SHALL be undefined-for-use, though stable and not X, during SHIFT.
REQ-017 start SHALL be ignored in SHIFT and DONE, with no effect on the operation in flight; start held high in IDLE after DONE SHALL begin a new operation.
REQ-018 The counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL never wrap during an operation.
REQ-019 Changes to a or b after acceptance SHALL NOT affect the result.

Reset
REQ-020 Asserting rst SHALL immediately, without waiting for clk, force state IDLE, busy=0, done=0, sum=0, cout=0, carry=0, counter=0 and operand registers=0.
REQ-021 rst asserted mid-operation SHALL abort the operation with no done pulse; start on the first edge after rst deasserts SHALL be accepted normally.

Structure
REQ-022 Package serial_adder_pkg SHALL hold the state enum type (IDLE, SHIFT, DONE) and the constant DEFAULT_WIDTH=8.
REQ-023 The per-bit full adder SHALL be built from two instances of the existing halfadder sub-module (ports a, b, sum, cout) plus an OR of their carries; no other sub-module is used.

Verification
REQ-024 With WIDTH=8: reset, then start with a=0x00 and b=0x00 -> busy rises the next cycle, done pulses exactly 9 edges after acceptance, sum=0x00, cout=0.
REQ-025 a=0xFF, b=0x01 -> sum=0x00, cout=1 at done; a=0xA5, b=0x5A -> sum=0xFF, cout=0.
REQ-026 a=0x80, b=0x80, with start held high continuously -> sum=0x00, cout=1 at each done, a new operation starting on the edge after each DONE, and no start accepted during SHIFT.
REQ-027 Start accepted with a=0x12, b=0x34, then start pulsed with a=0xFF, b=0xFF on cycle 4 -> result stays 0x46, cout=0, with one done only.
REQ-028 rst asserted asynchronously between edges on cycle 5 of an operation -> outputs go to 0 before the next edge, no done pulse; a later start with a=0x0F, b=0x01 -> sum=0x10.
REQ-029 Random test: 1000 random a/b pairs checked against an a+b reference model, with the done-latency checked for every pair.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared types and constants for the bit-serial adder
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_if.sv
// rtl/serial_adder_if.sv - request/result bundle between a requester and the serial adder
interface serial_adder_if
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b,
    output busy, done, sum, cout
  );

endinterface

// File: rtl/halfadder.sv
// rtl/halfadder.sv - single-bit half adder
module halfadder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b;
  assign cout = a & b;

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - LSB-first bit-serial adder, one result bit per clock
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  serial_adder_if.slave bus
);

  localparam int              CNTW = $clog2(WIDTH + 1);
  localparam logic [CNTW-1:0] LAST = CNTW'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_r;
  logic             carry;
  logic [CNTW-1:0]  cnt;
  logic             busy_c;
  logic             done_c;

  logic ha0_s;
  logic ha0_c;
  logic ha1_s;
  logic ha1_c;
  logic fa_s;
  logic fa_c;

  // Full adder on the current LSBs: two half adders, carries ORed.
  halfadder u_ha0 (.a(a_sh[0]), .b(b_sh[0]), .sum(ha0_s), .cout(ha0_c));
  halfadder u_ha1 (.a(ha0_s),   .b(carry),   .sum(ha1_s), .cout(ha1_c));

  assign fa_s = ha1_s;
  assign fa_c = ha0_c | ha1_c;

  always_comb begin
    state_nxt = state;
    busy_c    = 1'b0;
    done_c    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) state_nxt = SHIFT;
      end
      SHIFT: begin
        busy_c = 1'b1;
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        busy_c    = 1'b1;
        done_c    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Result register and carry are only touched on accept and in SHIFT,
  // so the last sum/cout stays visible through DONE and IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      sum_r <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sh  <= bus.a;
            b_sh  <= bus.b;
            carry <= 1'b0;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          sum_r <= {fa_s, sum_r[WIDTH-1:1]};
          a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
          carry <= fa_c;
          cnt   <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = busy_c;
  assign bus.done = done_c;
  assign bus.sum  = sum_r;
  assign bus.cout = carry;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder at WIDTH=8
module tb_serial_adder;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] sum;
    logic         cout;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(W)) bus ();

  serial_adder #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Caller is just past a falling edge with the DUT idle.
  task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic [W-1:0] esum, input logic ecout, input string tag);
    int lat;
    bus.start = 1'b1;
    bus.a     = va;
    bus.b     = vb;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
    chk({tag, " busy after accept"}, 32'(bus.busy), 32'd1);
    lat = 0;
    while (bus.done !== 1'b1 && lat < 4 * W) begin
      @(negedge clk);
      lat++;
      bus.a = W'($urandom);
      bus.b = W'($urandom);
    end
    chk({tag, " latency"}, 32'(lat), 32'(W));
    chk({tag, " sum"}, 32'(bus.sum), 32'(esum));
    chk({tag, " cout"}, 32'(bus.cout), 32'(ecout));
    @(negedge clk);
    chk({tag, " done one cycle"}, 32'(bus.done), 32'd0);
    chk({tag, " idle after done"}, 32'(bus.busy), 32'd0);
    chk({tag, " sum held"}, 32'({bus.cout, bus.sum}), 32'({ecout, esum}));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         vecs[9];
    logic [W:0]   ref_sum;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int           ndone;
    int           last;

    vecs[0] = '{8'h00, 8'h00, 8'h00, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 8'h00, 1'b1};
    vecs[2] = '{8'hA5, 8'h5A, 8'hFF, 1'b0};
    vecs[3] = '{8'h80, 8'h80, 8'h00, 1'b1};
    vecs[4] = '{8'h12, 8'h34, 8'h46, 1'b0};
    vecs[5] = '{8'h0F, 8'h01, 8'h10, 1'b0};
    vecs[6] = '{8'hFF, 8'hFF, 8'hFE, 1'b1};
    vecs[7] = '{8'h7F, 8'h01, 8'h80, 1'b0};
    vecs[8] = '{8'h01, 8'hFE, 8'hFF, 1'b0};

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (2) @(negedge clk);
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset done", 32'(bus.done), 32'd0);
    chk("reset sum/cout", 32'({bus.cout, bus.sum}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].sum, vecs[i].cout, $sformatf("vec%0d", i));

    // start held high: back-to-back operations, one every W+2 cycles
    bus.start = 1'b1;
    bus.a     = 8'h80;
    bus.b     = 8'h80;
    ndone     = 0;
    last      = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        ndone++;
        chk("held start sum/cout", 32'({bus.cout, bus.sum}), 32'h100);
        if (last < 0) chk("held start first done", 32'(i), 32'(W + 1));
        else          chk("held start interval", 32'(i - last), 32'(W + 2));
        last = i;
      end
    end
    bus.start = 1'b0;
    chk("held start done count", 32'(ndone), 32'd4);
    repeat (2) @(negedge clk);

    // start pulse during SHIFT must be ignored
    bus.start = 1'b1;
    bus.a     = 8'h12;
    bus.b     = 8'h34;
    @(negedge clk);
    bus.start = 1'b0;
    ndone     = 0;
    for (int i = 1; i <= 3 * W; i++) begin
      if (i == 3) begin
        bus.start = 1'b1;
        bus.a     = 8'hFF;
        bus.b     = 8'hFF;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      if (bus.done === 1'b1) begin
        ndone++;
        chk("ignored start sum/cout", 32'({bus.cout, bus.sum}), 32'h046);
      end
    end
    chk("ignored start done count", 32'(ndone), 32'd1);

    // asynchronous reset mid-operation
    bus.start = 1'b1;
    bus.a     = 8'hFF;
    bus.b     = 8'hFF;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("busy before abort", 32'(bus.busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort busy", 32'(bus.busy), 32'd0);
    chk("abort done", 32'(bus.done), 32'd0);
    chk("abort sum/cout", 32'({bus.cout, bus.sum}), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no done in reset", 32'(bus.done), 32'd0);
    end
    rst = 1'b0;
    run_op(8'h0F, 8'h01, 8'h10, 1'b0, "after reset");

    for (int i = 0; i < 1000; i++) begin
      ra      = W'($urandom);
      rb      = W'($urandom);
      ref_sum = {1'b0, ra} + {1'b0, rb};
      run_op(ra, rb, ref_sum[W-1:0], ref_sum[W], $sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
